axi_ram_responder: RTL and testbench

AXI3-style slave responder: the far end of the core's sram-like-to-AXI bridge, serving its AR/R/AW/W/B traffic from an internal word-addressed RAM. Used as the behavioural memory in block- and SoC-level simulation, and as a small on-chip RAM. Read and write channels are independent; each handles one outstanding transaction with INCR/FIXED bursts and configurable read latency.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_ram_core.sv | 32 +++
 rtl/axi_ram_responder.sv | 194 +++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the RAM responder.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

endpackage

// File: rtl/axi_ram_core.sv
// Word-addressed 32-bit RAM: one byte-enable write port, one registered read port.
module axi_ram_core #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              re,
  input  logic [MEM_AW-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wstrb[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Read register samples the pre-write word on a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI3-style slave serving independent read/write channels from an internal RAM.
module axi_ram_responder
  import axi_pkg::*;
#(
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned READ_DELAY = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  logic unused_ok;
  assign unused_ok = ^{arsize, arlock, arcache, awsize, awlock, awcache, awprot, wid,
                       araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

  rstate_e           r_state, r_next;
  logic [3:0]        r_cnt;
  logic [7:0]        r_left;
  logic [MEM_AW-1:0] r_idx, r_idx_nxt;
  burst_e            r_burst;
  logic [3:0]        r_id;
  logic              ar_hs, r_hs, r_last;
  logic              rd_en;
  logic [MEM_AW-1:0] rd_addr;

  wstate_e           w_state, w_next;
  logic [7:0]        w_left;
  logic [MEM_AW-1:0] w_idx, w_idx_nxt;
  burst_e            w_burst;
  logic [3:0]        w_id;
  logic              w_err;
  logic              aw_hs, w_hs, w_final;

  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid && rready;
  assign r_last    = (r_left == 8'd0);
  assign r_idx_nxt = (r_burst == BURST_FIXED) ? r_idx : r_idx + MEM_AW'(1);

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign w_final   = (w_left == 8'd0);
  assign w_idx_nxt = (w_burst == BURST_FIXED) ? w_idx : w_idx + MEM_AW'(1);

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)            r_next = R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0)    r_next = R_DATA;
      R_DATA:  if (r_hs && r_last)   r_next = R_IDLE;
      default:                       r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = (r_state == R_DATA) && r_last;
    rresp   = RESP_OKAY;
    rid     = r_id;
    // First beat loads from the latched index; later beats prefetch the next one on handshake.
    rd_en   = ((r_state == R_WAIT) && (r_cnt == 4'd0)) || (r_hs && !r_last);
    rd_addr = (r_state == R_WAIT) ? r_idx : r_idx_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_left  <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      if (ar_hs) begin
        r_id    <= arid;
        r_idx   <= araddr[MEM_AW+1:2];
        r_left  <= arlen;
        r_burst <= burst_e'(arburst);
        r_cnt   <= 4'(READ_DELAY);
      end else if ((r_state == R_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_hs && !r_last) begin
        r_left <= r_left - 8'd1;
        r_idx  <= r_idx_nxt;
      end
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)           w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (bready)          w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bid     = w_id;
    bresp   = w_err ? RESP_SLVERR : RESP_OKAY;
  end

  // Burst length is governed by the counter; wlast only feeds the error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_left  <= '0;
      w_err   <= 1'b0;
      w_burst <= BURST_FIXED;
    end else begin
      if (aw_hs) begin
        w_id    <= awid;
        w_idx   <= awaddr[MEM_AW+1:2];
        w_left  <= awlen;
        w_burst <= burst_e'(awburst);
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_err <= w_err | (wlast != w_final);
        if (!w_final) begin
          w_left <= w_left - 8'd1;
          w_idx  <= w_idx_nxt;
        end
      end
    end
  end

  axi_ram_core #(
    .MEM_AW(MEM_AW)
  ) u_core (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (w_hs),
    .waddr (w_idx),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_axi_ram_responder.sv
// Scoreboard bench for axi_ram_responder: directed transactions, decoupled R/B monitor.
module tb_axi_ram_responder;
  localparam int unsigned RD = 1;

  logic        aclk, aresetn;
  logic [3:0]  arid;  logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
  logic [1:0]  arburst, arlock; logic [3:0] arcache; logic arvalid, arready;
  logic [3:0]  rid;   logic [31:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0]  awid;  logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0]  awburst, awlock; logic [3:0] awcache; logic [2:0] awprot; logic awvalid, awready;
  logic [3:0]  wid;   logic [31:0] wdata;  logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0]  bid;   logic [1:0] bresp;   logic bvalid, bready;

  axi_ram_responder #(.MEM_AW(12), .READ_DELAY(RD)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed { logic [3:0] id; logic [31:0] data; logic last; } rexp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t r_q[$];
  bexp_t b_q[$];

  int tests = 0;
  int fails = 0;
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] rd [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Monitor: compares every presented R/B beat against the front of its queue.
  always @(negedge aclk) begin
    if (aresetn && rvalid) begin
      if (r_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: rid=%0h rdata=%0h", rid, rdata);
      end else begin
        chk("r_beat", {rid, rdata, rlast, rresp, arready},
            {r_q[0].id, r_q[0].data, r_q[0].last, 2'b00, 1'b0});
        if (rready) void'(r_q.pop_front());
      end
    end
    if (aresetn && bvalid && bready) begin
      if (b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: bid=%0h bresp=%0h", bid, bresp);
      end else begin
        chk("b_resp", {bid, bresp}, {b_q[0].id, b_q[0].resp});
        void'(b_q.pop_front());
      end
    end
  end

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int last_at, input int gap);
    bit ok;
    bexp_t e;
    e.id = id;
    e.resp = (last_at == int'(len)) ? 2'b00 : 2'b10;
    b_q.push_back(e);
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) timeout("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int g = 0; g < gap; g++) begin @(posedge aclk); #1; end
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == last_at);
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge aclk);
        if (wready) begin ok = 1; break; end
      end
      if (!ok) timeout("w_handshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    chk("bvalid_next_cycle", {63'd0, bvalid}, 64'd1);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      if (b_q.size() == 0) begin ok = 1; break; end
      @(negedge aclk);
    end
    if (!ok) timeout("b_drain");
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic rr0);
    bit ok;
    rexp_t e;
    for (int b = 0; b <= int'(len); b++) begin
      e.id = id; e.data = rd[b]; e.last = (b == int'(len));
      r_q.push_back(e);
    end
    @(posedge aclk); #1;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = rr0;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge aclk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] pat, input bit chk_lat);
    bit ok;
    int n;
    int k;
    issue_ar(id, addr, len, burst, pat[0]);
    if (chk_lat) begin
      n = 0; ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge aclk);
        if (c == 0) chk("arready_low_after_ar", {63'd0, arready}, 64'd0);
        if (rvalid) begin ok = 1; break; end
        @(posedge aclk);
        n++;
      end
      if (!ok) timeout("rvalid_latency");
      else chk("rvalid_latency", 64'(n), 64'(RD + 1));
    end
    k = 0; ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge aclk); #1;
      if (r_q.size() == 0) begin ok = 1; break; end
      k++;
      rready = pat[k % 4];
    end
    if (!ok) timeout("r_drain");
    rready = 1'b1;
    @(negedge aclk);
    chk("arready_after_burst", {63'd0, arready}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
    arcache = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; rd[i] = '0; end

    #23;
    chk("reset_ready", {62'd0, arready, awready}, 64'd3);
    chk("reset_valid", {60'd0, rvalid, rlast, wready, bvalid}, 64'd0);
    chk("reset_payload", {rid, rdata, rresp, bid, bresp}, 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // single write then read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(4'h5, 32'h100, 8'd0, 2'b01, 0, 0);
    rd[0] = 32'hDEADBEEF;
    do_read(4'h3, 32'h100, 8'd0, 2'b01, 4'b1111, 1);

    // byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'h1, 32'h20, 8'd0, 2'b01, 0, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(4'h2, 32'h20, 8'd0, 2'b01, 0, 0);
    ws[0] = 4'hF;
    rd[0] = 32'h11BB33DD;
    do_read(4'h4, 32'h20, 8'd0, 2'b01, 4'b1111, 0);

    // INCR burst with rready backpressure 1,0,1,0
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i); rd[i] = 32'(i); end
    do_write(4'h6, 32'h40, 8'd3, 2'b01, 3, 0);
    do_read(4'h7, 32'h40, 8'd3, 2'b01, 4'b0101, 1);

    // FIXED burst with early wlast
    wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
    do_write(4'h8, 32'h80, 8'd2, 2'b00, 1, 0);
    rd[0] = 32'd7;
    do_read(4'h9, 32'h80, 8'd0, 2'b01, 4'b1111, 0);

    // same-edge read load and write to word 0
    wd[0] = 32'd4;
    do_write(4'hA, 32'h0, 8'd0, 2'b01, 0, 0);
    rd[0] = 32'd4; wd[0] = 32'd9;
    fork
      do_read(4'h1, 32'h0, 8'd0, 2'b01, 4'b1111, 0);
      do_write(4'h2, 32'h0, 8'd0, 2'b01, 0, 1);
    join
    rd[0] = 32'd9;
    do_read(4'hB, 32'h0, 8'd0, 2'b01, 4'b1111, 0);

    // INCR wrap from last word to word 0, and address aliasing
    wd[0] = 32'hCAFE0001;
    do_write(4'hC, 32'h3FFC, 8'd0, 2'b01, 0, 0);
    rd[0] = 32'hCAFE0001; rd[1] = 32'd9;
    do_read(4'hD, 32'h3FFC, 8'd1, 2'b01, 4'b1111, 0);
    rd[0] = 32'hDEADBEEF;
    do_read(4'hE, 32'h4100, 8'd0, 2'b01, 4'b1111, 0);

    // reset during beat 2 of a 4-beat read
    for (int i = 0; i < 4; i++) rd[i] = 32'(i);
    issue_ar(4'hF, 32'h40, 8'd3, 2'b01, 1'b1);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (rvalid) begin ok = 1; break; end
    end
    if (!ok) timeout("rst_burst_start");
    @(posedge aclk); #1 rready = 1'b0;
    @(negedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_ready", {62'd0, arready, awready}, 64'd3);
    chk("midrst_valid", {61'd0, rvalid, rlast, bvalid}, 64'd0);
    chk("midrst_payload", {rid, rdata, bid, bresp}, 64'd0);
    r_q.delete();
    @(posedge aclk); @(posedge aclk); #1;
    aresetn = 1'b1; rready = 1'b1;

    rd[0] = 32'hDEADBEEF;
    do_read(4'h3, 32'h100, 8'd0, 2'b01, 4'b1111, 0);
    for (int i = 0; i < 4; i++) rd[i] = 32'(i);
    do_read(4'h5, 32'h40, 8'd3, 2'b01, 4'b1111, 0);

    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
